// File: rtl/pr_role_quiesce_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pr_role_quiesce_ctrl_if
// Description : Address-channel handshake and response-monitor bundle used by
//               the partial-reconfiguration quiesce controller.
//                 role_aw*/role_ar*  : role-facing side of the AW/AR valid/ready
//                 s_aw*/s_ar*        : static-facing side of the AW/AR valid/ready
//                 bvalid/bready      : write-response handshake (monitored only)
//                 rvalid/rready/rlast: read-data handshake (monitored only)
//               Modports:
//                 master : the quiesce controller (drives s_*valid, role_*ready)
//                 slave  : the surrounding role/static fabric
// Revision    : 1.0  initial release
// ============================================================================
interface pr_role_quiesce_ctrl_if;
   logic role_awvalid;
   logic role_awready;
   logic s_awvalid;
   logic s_awready;
   logic role_arvalid;
   logic role_arready;
   logic s_arvalid;
   logic s_arready;
   logic bvalid;
   logic bready;
   logic rvalid;
   logic rready;
   logic rlast;

   modport master (
      input  role_awvalid, s_awready, role_arvalid, s_arready,
      input  bvalid, bready, rvalid, rready, rlast,
      output s_awvalid, role_awready, s_arvalid, role_arready
   );

   modport slave (
      output role_awvalid, s_awready, role_arvalid, s_arready,
      output bvalid, bready, rvalid, rready, rlast,
      input  s_awvalid, role_awready, s_arvalid, role_arready
   );
endinterface
`default_nettype wire

// File: rtl/pr_role_quiesce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pr_role_quiesce_ctrl
// Description : Sequences safe partial reconfiguration of one role's AXI4
//               master path. Sits on the AW/AR valid/ready pairs, tracks
//               outstanding writes/reads from the B and R (rlast) handshakes,
//               and on decouple_req blocks new addresses, drains, then raises
//               decouple and holds the role in reset.
// Ports       : CLK_IN_250    sole clock
//               AXI_RESET_N   synchronous active-low reset
//               axi           handshake bundle (master modport)
//               decouple_req  level request from static AXI-lite register
//               decouple      1 = static side isolates all role AXI signals
//               role_reset_n  active-low reset to the role
//               status        {timeout_flag, cnt_err, decouple}
// Options     : PR_QUIESCE_TIMEOUT_EN - when defined, BLOCK is bounded by
//               TIMEOUT_CYCLES and a forced decouple sets timeout_flag.
// Revision    : 1.0  initial release
// ============================================================================
module pr_role_quiesce_ctrl #(
   parameter int OUTS_W          = 4,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic                          CLK_IN_250,
   input  logic                          AXI_RESET_N,
   pr_role_quiesce_ctrl_if.master        axi,
   input  logic                          decouple_req,
   output logic                          decouple,
   output logic                          role_reset_n,
   output logic [2:0]                    status
);

   localparam logic [OUTS_W-1:0] CNT_MAX   = '1;
   localparam int                HOLD_W    = (RST_HOLD_CYCLES > 2) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_BLOCK     = 2'd1,
      ST_DECOUPLED = 2'd2,
      ST_RELEASE   = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [OUTS_W-1:0]   wr_cnt;
   logic [OUTS_W-1:0]   rd_cnt;
   logic                aw_hold;
   logic                ar_hold;
   logic                cnt_err;
   logic                timeout_flag;
   logic                tmo_hit;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                por_busy;

   logic                block;
   logic                live;
   logic                pass_aw;
   logic                pass_ar;
   logic                aw_acc;
   logic                ar_acc;
   logic                b_done;
   logic                r_done;
   logic                drained;
   logic                enter_dec;

   // -------------------------------------------------------------------------
   // Address-channel gating. A valid already presented to the static side
   // (aw_hold/ar_hold) always passes so it is never withdrawn mid-handshake.
   // -------------------------------------------------------------------------
   assign block   = (state != ST_RUN);
   assign live    = (state == ST_RUN) || (state == ST_BLOCK);
   assign pass_aw = (!block && (wr_cnt != CNT_MAX)) || aw_hold;
   assign pass_ar = (!block && (rd_cnt != CNT_MAX)) || ar_hold;

   assign axi.s_awvalid    = axi.role_awvalid & pass_aw;
   assign axi.role_awready = axi.s_awready    & pass_aw;
   assign axi.s_arvalid    = axi.role_arvalid & pass_ar;
   assign axi.role_arready = axi.s_arready    & pass_ar;

   assign aw_acc = axi.s_awvalid & axi.s_awready;
   assign ar_acc = axi.s_arvalid & axi.s_arready;
   assign b_done = axi.bvalid & axi.bready;
   assign r_done = axi.rvalid & axi.rready & axi.rlast;

   assign drained   = (wr_cnt == '0) && (rd_cnt == '0) && !aw_hold && !ar_hold;
   assign enter_dec = (state == ST_BLOCK) && (state_nxt == ST_DECOUPLED);

   // -------------------------------------------------------------------------
   // State machine
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN_250) begin
      if (!AXI_RESET_N) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (decouple_req) state_nxt = ST_BLOCK;
         end
         ST_BLOCK: begin
            if (drained || tmo_hit)  state_nxt = ST_DECOUPLED;
            else if (!decouple_req)  state_nxt = ST_RUN;
         end
         ST_DECOUPLED: begin
            if (!decouple_req) state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (hold_cnt == '0) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outstanding counters. Simultaneous increment and decrement cancel; an
   // underflow attempt leaves the counter at zero and flags cnt_err. Counters
   // are frozen while decoupled and zeroed on entry to DECOUPLED.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN_250) begin
      if (!AXI_RESET_N) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         aw_hold <= 1'b0;
         ar_hold <= 1'b0;
         cnt_err <= 1'b0;
      end else begin
         aw_hold <= enter_dec ? 1'b0 : (axi.s_awvalid & ~axi.s_awready);
         ar_hold <= enter_dec ? 1'b0 : (axi.s_arvalid & ~axi.s_arready);

         if (live && ((b_done && !aw_acc && (wr_cnt == '0)) ||
                      (r_done && !ar_acc && (rd_cnt == '0)))) begin
            cnt_err <= 1'b1;
         end

         if (enter_dec) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
         end else if (live) begin
            if (aw_acc && !b_done) begin
               if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
            end else if (b_done && !aw_acc) begin
               if (wr_cnt != '0) wr_cnt <= wr_cnt - 1'b1;
            end

            if (ar_acc && !r_done) begin
               if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
            end else if (r_done && !ar_acc) begin
               if (rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Role reset hold. One down-counter serves both the power-on hold after
   // AXI_RESET_N and the post-release hold; DECOUPLED reloads it and ends any
   // power-on hold still running, since RELEASE provides its own full hold.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN_250) begin
      if (!AXI_RESET_N) begin
         hold_cnt <= HOLD_LOAD;
         por_busy <= 1'b1;
      end else begin
         case (state)
            ST_DECOUPLED: begin
               hold_cnt <= HOLD_LOAD;
               por_busy <= 1'b0;
            end
            ST_RELEASE: begin
               if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            end
            default: begin
               if (por_busy) begin
                  if (hold_cnt == '0) por_busy <= 1'b0;
                  else                hold_cnt <= hold_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Drain timeout
   // -------------------------------------------------------------------------
`ifdef PR_QUIESCE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = (state == ST_BLOCK) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK_IN_250) begin
      if (!AXI_RESET_N) begin
         tmo_cnt      <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state == ST_BLOCK) tmo_cnt <= tmo_cnt + 1'b1;
         else                   tmo_cnt <= '0;
         // A drain that completes on the last allowed cycle is not a timeout.
         if (tmo_hit && !drained) timeout_flag <= 1'b1;
      end
   end
`else
   // Without the timeout option BLOCK waits indefinitely; TIMEOUT_CYCLES is
   // referenced here only so the parameter stays part of the interface.
   logic unused_tmo;
   assign unused_tmo   = (TIMEOUT_CYCLES == 0);
   assign tmo_hit      = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign decouple     = (state == ST_DECOUPLED) || (state == ST_RELEASE);
   assign role_reset_n = live && !por_busy;
   assign status       = {timeout_flag, cnt_err, decouple};

endmodule
`default_nettype wire

// File: tb/tb_pr_role_quiesce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pr_role_quiesce_ctrl
// Description : Directed self-checking bench for pr_role_quiesce_ctrl built
//               with OUTS_W=2 (counter ceiling 3) and RST_HOLD_CYCLES=16.
//               Expected values are queued as stimulus is applied and popped
//               when the corresponding DUT output is sampled.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pr_role_quiesce_ctrl;

   logic       clk;
   logic       rst_n;
   logic       decouple_req;
   logic       decouple;
   logic       role_reset_n;
   logic [2:0] status;

   pr_role_quiesce_ctrl_if bus ();

   pr_role_quiesce_ctrl #(
      .OUTS_W          (2),
      .RST_HOLD_CYCLES (16),
      .TIMEOUT_CYCLES  (65535)
   ) dut (
      .CLK_IN_250   (clk),
      .AXI_RESET_N  (rst_n),
      .axi          (bus.master),
      .decouple_req (decouple_req),
      .decouple     (decouple),
      .role_reset_n (role_reset_n),
      .status       (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic expect_val(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [7:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drop the request from DECOUPLED and measure the role-reset hold.
   task automatic release_seq(input string tag);
      int n;
      decouple_req = 1'b0;
      tick();
      expect_val({tag, "_release_hold"}, 8'd16);
      n = 0;
      while (role_reset_n == 1'b0 && n < 40) begin
         n++;
         tick();
      end
      check(8'(n));
      expect_val({tag, "_release_decouple"}, 8'd0);
      check({7'd0, decouple});
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n            = 1'b0;
      decouple_req     = 1'b0;
      bus.role_awvalid = 1'b0;
      bus.s_awready    = 1'b0;
      bus.role_arvalid = 1'b0;
      bus.s_arready    = 1'b0;
      bus.bvalid       = 1'b0;
      bus.bready       = 1'b0;
      bus.rvalid       = 1'b0;
      bus.rready       = 1'b0;
      bus.rlast        = 1'b0;
      repeat (3) tick();

      // Reset state
      expect_val("rst_status", 8'd0);
      expect_val("rst_decouple", 8'd0);
      expect_val("rst_role_reset_n", 8'd0);
      check({5'd0, status});
      check({7'd0, decouple});
      check({7'd0, role_reset_n});

      // Power-on role reset hold
      rst_n = 1'b1;
      expect_val("por_hold", 8'd16);
      n = 0;
      while (role_reset_n == 1'b0 && n < 40) begin
         tick();
         n++;
      end
      check(8'(n));

      // 1: idle request -> decouple two cycles later, AW blocked
      decouple_req = 1'b1;
      tick();
      expect_val("t1_block_decouple", 8'd0);
      check({7'd0, decouple});
      bus.role_awvalid = 1'b1;
      bus.s_awready    = 1'b1;
      #1;
      expect_val("t1_awvalid_blocked", 8'd0);
      expect_val("t1_awready_blocked", 8'd0);
      check({7'd0, bus.s_awvalid});
      check({7'd0, bus.role_awready});
      tick();
      expect_val("t1_decouple", 8'd1);
      expect_val("t1_role_reset_n", 8'd0);
      expect_val("t1_status", 8'd1);
      expect_val("t1_awvalid_decoupled", 8'd0);
      check({7'd0, decouple});
      check({7'd0, role_reset_n});
      check({5'd0, status});
      check({7'd0, bus.s_awvalid});
      bus.role_awvalid = 1'b0;
      bus.s_awready    = 1'b0;
      release_seq("t1");

      // 2: three writes outstanding (ceiling), two B back, then drain on the third
      bus.role_awvalid = 1'b1;
      bus.s_awready    = 1'b1;
      repeat (3) tick();
      expect_val("t2_aw_full_ready", 8'd0);
      expect_val("t2_aw_full_valid", 8'd0);
      check({7'd0, bus.role_awready});
      check({7'd0, bus.s_awvalid});
      bus.role_awvalid = 1'b0;
      bus.s_awready    = 1'b0;
      bus.bvalid       = 1'b1;
      bus.bready       = 1'b1;
      repeat (2) tick();
      bus.bvalid       = 1'b0;
      decouple_req     = 1'b1;
      repeat (4) tick();
      expect_val("t2_wait_block", 8'd0);
      check({7'd0, decouple});
      bus.bvalid = 1'b1;
      tick();
      bus.bvalid = 1'b0;
      expect_val("t2_after_last_b", 8'd0);
      check({7'd0, decouple});
      tick();
      expect_val("t2_decoupled", 8'd1);
      expect_val("t2_status", 8'd1);
      check({7'd0, decouple});
      check({5'd0, status});
      release_seq("t2");

      // 3: valid pending at static when request rises is held until accepted
      bus.role_awvalid = 1'b1;
      bus.s_awready    = 1'b0;
      #1;
      expect_val("t3_valid_run", 8'd1);
      check({7'd0, bus.s_awvalid});
      decouple_req = 1'b1;
      tick();
      expect_val("t3_hold_1", 8'd1);
      check({7'd0, bus.s_awvalid});
      tick();
      expect_val("t3_hold_2", 8'd1);
      expect_val("t3_block", 8'd0);
      check({7'd0, bus.s_awvalid});
      check({7'd0, decouple});
      bus.s_awready = 1'b1;
      #1;
      expect_val("t3_ready_pass", 8'd1);
      check({7'd0, bus.role_awready});
      tick();
      expect_val("t3_post_accept", 8'd0);
      check({7'd0, bus.s_awvalid});
      bus.role_awvalid = 1'b0;
      bus.s_awready    = 1'b0;
      repeat (2) tick();
      expect_val("t3_wait_b", 8'd0);
      check({7'd0, decouple});
      bus.bvalid = 1'b1;
      tick();
      bus.bvalid = 1'b0;
      tick();
      expect_val("t3_decoupled", 8'd1);
      check({7'd0, decouple});
      release_seq("t3");

      // 4: read ceiling; only an rlast beat frees a slot
      bus.role_arvalid = 1'b1;
      bus.s_arready    = 1'b1;
      repeat (3) tick();
      expect_val("t4_ar_full", 8'd0);
      check({7'd0, bus.role_arready});
      bus.rvalid = 1'b1;
      bus.rready = 1'b1;
      bus.rlast  = 1'b0;
      tick();
      expect_val("t4_ar_full_nolast", 8'd0);
      check({7'd0, bus.role_arready});
      bus.rlast = 1'b1;
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      expect_val("t4_ar_open", 8'd1);
      check({7'd0, bus.role_arready});
      bus.role_arvalid = 1'b0;
      bus.s_arready    = 1'b0;
      bus.rvalid       = 1'b1;
      bus.rlast        = 1'b1;
      repeat (2) tick();
      bus.rvalid       = 1'b0;
      bus.rlast        = 1'b0;
      decouple_req     = 1'b1;
      tick();
      tick();
      expect_val("t4_decoupled", 8'd1);
      expect_val("t4_status", 8'd1);
      check({7'd0, decouple});
      check({5'd0, status});
      release_seq("t4");

      // 5: simultaneous accept and B cancel; B at zero sets sticky cnt_err
      bus.role_awvalid = 1'b1;
      bus.s_awready    = 1'b1;
      tick();
      bus.bvalid = 1'b1;
      bus.bready = 1'b1;
      tick();
      bus.role_awvalid = 1'b0;
      bus.s_awready    = 1'b0;
      bus.bvalid       = 1'b0;
      expect_val("t5_no_err", 8'd0);
      check({5'd0, status});
      decouple_req = 1'b1;
      repeat (3) tick();
      expect_val("t5_cnt_held", 8'd0);
      check({7'd0, decouple});
      bus.bvalid = 1'b1;
      tick();
      bus.bvalid = 1'b0;
      tick();
      expect_val("t5_drained", 8'd1);
      check({7'd0, decouple});
      release_seq("t5");
      bus.bvalid = 1'b1;
      tick();
      bus.bvalid = 1'b0;
      expect_val("t5_cnt_err", 8'd2);
      check({5'd0, status});
      decouple_req = 1'b1;
      tick();
      tick();
      expect_val("t5_zero_floor", 8'd3);
      check({5'd0, status});

      // 6: reset while decoupled returns straight to reset state
      rst_n = 1'b0;
      tick();
      expect_val("t6_rst_status", 8'd0);
      expect_val("t6_rst_role_reset_n", 8'd0);
      check({5'd0, status});
      check({7'd0, role_reset_n});
      rst_n        = 1'b1;
      decouple_req = 1'b0;
      repeat (2) tick();
      expect_val("t6_after_rst_status", 8'd0);
      check({5'd0, status});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
